mem_write_ctrl: RTL and testbench
=================================

MEM_WRITE_CTRL -- requirements
Module: mem_write_ctrl

Interface
REQ-001 SHALL have parameter D_W, default 8: data width per channel.
REQ-002 SHALL have parameter N, default 3: channel (systolic column) count.
REQ-003 SHALL have parameter M, default 6: matrix dimension; DEPTH = (M*M)/N words per channel per frame.
REQ-004 SHALL have parameter NBANK, default 2: frame banks per BRAM; AW = $clog2(DEPTH*NBANK).
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  [N-1:0]  per-channel data valid.
REQ-009 in_data  input  [D_W-1:0] x N  per-channel data.
REQ-010 in_ready  output  [N-1:0]  per-channel accept; transfer = in_valid[x] & in_ready[x].
REQ-011 bank_release  input  1  one-cycle pulse: reader has freed the oldest full bank.
REQ-012 wr_addr_bram  output  [AW-1:0] x N  registered BRAM write address.
REQ-013 wr_data_bram  output  [D_W-1:0] x N  registered BRAM write data.
REQ-014 wr_en_bram  output  [N-1:0]  registered BRAM write enable.
REQ-015 frame_done  output  1  one-cycle pulse: a frame completed.
REQ-016 frame_bank  output  [$clog2(NBANK)-1:0]  bank just completed; valid with frame_done.
REQ-017 full  output  1  all NBANK banks hold unreleased frames.
REQ-018 err_release  output  1  sticky: bank_release received with no full bank.

Function
REQ-019 SHALL keep per-channel counter cnt[x] (0..DEPTH), write bank wr_bank, full-bank count nfull (0..NBANK).
REQ-020 SHALL run FSM states FILL, COMMIT, STALL.
REQ-021 in_ready[x] SHALL = (state==FILL) & (cnt[x] < DEPTH); 0 in COMMIT/STALL.
REQ-022 On transfer on channel x: next cycle wr_en_bram[x]=1, wr_data_bram[x]=in_data[x], wr_addr_bram[x]=wr_bank*DEPTH+cnt[x]; cnt[x] increments. Latency exactly 1 cycle.
REQ-023 Without transfer, wr_en_bram[x]=0; wr_addr_bram/wr_data_bram SHALL hold last values.
REQ-024 Channels SHALL advance independently; a channel reaching DEPTH waits (in_ready low) until all reach DEPTH.
REQ-025 FILL->COMMIT when every cnt[x]==DEPTH.
REQ-026 In COMMIT (one cycle): frame_done=1, frame_bank=wr_bank; wr_bank advances mod NBANK; all cnt cleared; nfull+1.
REQ-027 COMMIT->FILL if updated nfull<NBANK, else COMMIT->STALL with full=1.
REQ-028 STALL->FILL on bank_release; full deasserts same edge.
REQ-029 bank_release with nfull>0 SHALL decrement nfull; same-cycle commit and release SHALL leave nfull unchanged and never enter STALL.
REQ-030 bank_release with nfull==0 and no same-cycle commit SHALL be ignored and set err_release.
REQ-031 full SHALL = (nfull==NBANK), registered.
REQ-032 NBANK=1 SHALL operate single-buffered: every frame stalls until released.

Reset
REQ-033 rst_n low SHALL immediately clear cnt, wr_bank, nfull, frame_done, frame_bank, full, err_release, wr_en_bram, wr_addr_bram, wr_data_bram; state=FILL; in_ready=0 while rst_n low.
REQ-034 Reset mid-frame SHALL discard partial frame; first write after release goes to address 0.

Structure
REQ-035 Package mem_write_pkg SHALL hold the FSM state enum and a depth/address-width function.
REQ-036 Sub-module mem_write_chan SHALL implement one channel's counter, address formation and output register; instantiated N times.

Verification (N=3, M=6, NBANK=2: DEPTH=12, AW=5)
REQ-037 Reset asserted -> all outputs 0, in_ready=000; release -> in_ready=111.
REQ-038 All valid 12 cycles -> each channel writes addr 0..11 at latency 1; frame_done, frame_bank=0; next frame addr 12..23.
REQ-039 ch0 valid continuously, ch1/ch2 half duty -> in_ready[0]=0 after 12 writes until ch1/ch2 finish; single frame_done.
REQ-040 Two frames, no release -> full=1, state STALL, in_ready=000; bank_release -> full=0, next write addr 0.
REQ-041 bank_release in COMMIT cycle of frame 2 with nfull=1 -> nfull stays 1, full=0, no stall; release at nfull=0 -> err_release=1.
REQ-042 rst_n low after 5 writes -> outputs clear immediately; after release, writes restart at addr 0, bank 0.

Source files
------------

// File: rtl/mem_write_pkg.sv
// Shared types and sizing helpers for the multi-channel BRAM write controller.
package mem_write_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_STALL  = 2'd2
  } wr_state_t;

  // Never returns less than 1 so degenerate parameters still give legal vectors.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned calc_depth(input int unsigned m, input int unsigned n);
    return (m * m) / n;
  endfunction

  function automatic int unsigned calc_aw(input int unsigned m, input int unsigned n,
                                          input int unsigned nbank);
    return clog2_min1(calc_depth(m, n) * nbank);
  endfunction

endpackage

// File: rtl/mem_write_ctrl_if.sv
// Per-channel input stream and registered BRAM write bus of mem_write_ctrl.
interface mem_write_ctrl_if #(
  parameter int unsigned D_W = 8,
  parameter int unsigned N   = 3,
  parameter int unsigned AW  = 5
) ();

  logic [N-1:0]           in_valid;
  logic [N-1:0][D_W-1:0]  in_data;
  logic [N-1:0]           in_ready;
  logic [N-1:0][AW-1:0]   wr_addr_bram;
  logic [N-1:0][D_W-1:0]  wr_data_bram;
  logic [N-1:0]           wr_en_bram;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_addr_bram, wr_data_bram, wr_en_bram
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_addr_bram, wr_data_bram, wr_en_bram
  );

endinterface

// File: rtl/mem_write_chan.sv
// One channel: word counter, bank-relative address formation and the
// registered BRAM write port.
module mem_write_chan #(
  parameter int unsigned D_W   = 8,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 12,
  parameter int unsigned CW    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_fill,
  input  logic           i_clear,
  input  logic [AW-1:0]  i_base,
  input  logic           i_valid,
  input  logic [D_W-1:0] i_data,
  output logic           o_ready,
  output logic           o_done,
  output logic [AW-1:0]  o_wr_addr,
  output logic [D_W-1:0] o_wr_data,
  output logic           o_wr_en
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]  r_cnt;
  logic [AW-1:0]  r_wr_addr;
  logic [D_W-1:0] r_wr_data;
  logic           r_wr_en;
  logic           w_xfer;

  assign o_ready   = i_fill & (r_cnt < DEPTH_C);
  assign o_done    = (r_cnt == DEPTH_C);
  assign w_xfer    = i_valid & o_ready;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_wr_en   = r_wr_en;

  // Address and data only move on a transfer; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_wr_en <= w_xfer;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt     <= r_cnt + CW'(1);
        r_wr_addr <= i_base + AW'(r_cnt);
        r_wr_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/mem_write_ctrl.sv
// Frame-banked write controller: N independent channels fill one bank of
// DEPTH words each, then the frame is committed and the next bank is used.
module mem_write_ctrl
  import mem_write_pkg::*;
#(
  parameter int unsigned D_W   = 8,
  parameter int unsigned N     = 3,
  parameter int unsigned M     = 6,
  parameter int unsigned NBANK = 2,
  localparam int unsigned DEPTH = calc_depth(M, N),
  localparam int unsigned AW    = calc_aw(M, N, NBANK),
  localparam int unsigned BW    = clog2_min1(NBANK),
  localparam int unsigned CW    = clog2_min1(DEPTH + 1),
  localparam int unsigned NFW   = clog2_min1(NBANK + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_write_ctrl_if.slave      bus,
  input  logic                 bank_release,
  output logic                 frame_done,
  output logic [BW-1:0]        frame_bank,
  output logic                 full,
  output logic                 err_release
);

  localparam logic [NFW-1:0] NBANK_C = NFW'(NBANK);
  localparam logic [BW-1:0]  LAST_B  = BW'(NBANK - 1);

  wr_state_t             r_state;
  logic [BW-1:0]         r_wr_bank;
  logic [NFW-1:0]        r_nfull;
  logic                  r_frame_done;
  logic [BW-1:0]         r_frame_bank;
  logic                  r_full;
  logic                  r_err;

  logic                  w_fill;
  logic                  w_commit;
  logic                  w_rel_ok;
  logic [NFW-1:0]        w_nfull_nxt;
  logic [BW-1:0]         w_bank_nxt;
  logic [AW-1:0]         w_base;
  logic [N-1:0]          w_ready;
  logic [N-1:0]          w_done;
  logic [N-1:0][AW-1:0]  w_wr_addr;
  logic [N-1:0][D_W-1:0] w_wr_data;
  logic [N-1:0]          w_wr_en;

  // rst_n gates ready so nothing is accepted while reset is held.
  assign w_fill     = (r_state == ST_FILL) & rst_n;
  assign w_commit   = (r_state == ST_COMMIT);
  assign w_base     = AW'(r_wr_bank) * AW'(DEPTH);
  assign w_bank_nxt = (r_wr_bank == LAST_B) ? '0 : r_wr_bank + BW'(1);

  // A release coinciding with a commit hands back the bank just filled.
  assign w_rel_ok = bank_release & (w_commit | (r_nfull != '0));

  always_comb begin
    w_nfull_nxt = r_nfull;
    if (w_commit && !w_rel_ok)
      w_nfull_nxt = r_nfull + NFW'(1);
    else if (!w_commit && w_rel_ok)
      w_nfull_nxt = r_nfull - NFW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_wr_bank    <= '0;
      r_nfull      <= '0;
      r_frame_done <= 1'b0;
      r_frame_bank <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_nfull      <= w_nfull_nxt;
      r_full       <= (w_nfull_nxt == NBANK_C);
      if (bank_release && !w_rel_ok)
        r_err <= 1'b1;
      case (r_state)
        ST_FILL: begin
          if (&w_done) begin
            r_state      <= ST_COMMIT;
            r_frame_done <= 1'b1;
            r_frame_bank <= r_wr_bank;
          end
        end
        ST_COMMIT: begin
          r_wr_bank <= w_bank_nxt;
          r_state   <= (w_nfull_nxt == NBANK_C) ? ST_STALL : ST_FILL;
        end
        ST_STALL: begin
          if (bank_release)
            r_state <= ST_FILL;
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    mem_write_chan #(
      .D_W  (D_W),
      .AW   (AW),
      .DEPTH(DEPTH),
      .CW   (CW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_fill   (w_fill),
      .i_clear  (w_commit),
      .i_base   (w_base),
      .i_valid  (bus.in_valid[g]),
      .i_data   (bus.in_data[g]),
      .o_ready  (w_ready[g]),
      .o_done   (w_done[g]),
      .o_wr_addr(w_wr_addr[g]),
      .o_wr_data(w_wr_data[g]),
      .o_wr_en  (w_wr_en[g])
    );
  end

  assign bus.in_ready     = w_ready;
  assign bus.wr_addr_bram = w_wr_addr;
  assign bus.wr_data_bram = w_wr_data;
  assign bus.wr_en_bram   = w_wr_en;

  assign frame_done  = r_frame_done;
  assign frame_bank  = r_frame_bank;
  assign full        = r_full;
  assign err_release = r_err;

endmodule

// File: tb/tb_mem_write_ctrl.sv
// Directed bench for mem_write_ctrl at N=3, M=6, NBANK=2 (DEPTH=12, AW=5).
module tb_mem_write_ctrl;

  localparam int unsigned D_W   = 8;
  localparam int unsigned N     = 3;
  localparam int unsigned M     = 6;
  localparam int unsigned NBANK = 2;
  localparam int unsigned AW    = 5;

  typedef struct {
    logic [2:0] v;
    logic       rel;
    logic [2:0] exp_rdy;
    logic [2:0] exp_en;
    logic [4:0] exp_addr;
    logic       exp_fd;
    logic       exp_fb;
    logic       exp_full;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bank_release = 1'b0;
  logic       frame_done;
  logic [0:0] frame_bank;
  logic       full;
  logic       err_release;

  int n_vec  = 0;
  int n_miss = 0;
  int unsigned seq = 0;
  logic [N-1:0][D_W-1:0] exp_data;
  vec_t tbl[$];

  mem_write_ctrl_if #(.D_W(D_W), .N(N), .AW(AW)) bus ();

  mem_write_ctrl #(
    .D_W  (D_W),
    .N    (N),
    .M    (M),
    .NBANK(NBANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .bank_release(bank_release),
    .frame_done  (frame_done),
    .frame_bank  (frame_bank),
    .full        (full),
    .err_release (err_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic rel);
    seq++;
    bus.in_valid = v;
    bank_release = rel;
    for (int c = 0; c < 3; c++) bus.in_data[c] = D_W'(c * 64 + int'(seq));
  endtask

  task automatic chk_cleared();
    chk("rst_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en_bram), 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk("rst_addr", 32'(bus.wr_addr_bram[c]), 32'h0);
      chk("rst_data", 32'(bus.wr_data_bram[c]), 32'h0);
    end
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    chk("rst_frame_bank", 32'(frame_bank), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_err", 32'(err_release), 32'h0);
    exp_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = '0;
    bank_release = 1'b0;
    #1;
    chk_cleared();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'h7);
  endtask

  // Twelve all-valid writes, the completion cycle, then the commit cycle.
  task automatic run_frame(input int bank, input logic rel_in_commit);
    for (int i = 0; i < 12; i++) begin
      chk("fr_ready", 32'(bus.in_ready), 32'h7);
      drive(3'b111, 1'b0);
      tick();
      chk("fr_en", 32'(bus.wr_en_bram), 32'h7);
      for (int c = 0; c < 3; c++)
        chk("fr_addr", 32'(bus.wr_addr_bram[c]), 32'(bank * 12 + i));
    end
    drive(3'b000, 1'b0);
    tick();
    chk("fr_done", 32'(frame_done), 32'h1);
    chk("fr_bank", 32'(frame_bank), 32'(bank));
    drive(3'b000, rel_in_commit);
    tick();
    chk("fr_done_pulse", 32'(frame_done), 32'h0);
    drive(3'b000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t t;
    int cm[3];
    int fd_cnt;
    logic [2:0] v, rdy_m;

    // Two frames without release, stall, release, first write back at bank 0.
    for (int i = 0; i < 12; i++) tbl.push_back('{3'b111, 1'b0, 3'b111, 3'b111, 5'(i), 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b000, 3'b000, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b000, 3'b000, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 12; i++) tbl.push_back('{3'b111, 1'b0, 3'b111, 3'b111, 5'(12 + i), 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b000, 3'b000, 5'd23, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b000, 3'b000, 5'd23, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b000, 3'b000, 5'd23, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{3'b111, 1'b1, 3'b000, 3'b000, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{3'b111, 1'b0, 3'b111, 3'b111, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0});

    bus.in_valid = '0;
    bus.in_data  = '0;
    #2;
    chk_cleared();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(bus.in_ready), 32'h7);

    foreach (tbl[i]) begin
      t = tbl[i];
      chk("tbl_ready", 32'(bus.in_ready), 32'(t.exp_rdy));
      drive(t.v, t.rel);
      tick();
      chk("tbl_wr_en", 32'(bus.wr_en_bram), 32'(t.exp_en));
      for (int c = 0; c < 3; c++) begin
        if (t.exp_en[c]) exp_data[c] = bus.in_data[c];
        chk("tbl_addr", 32'(bus.wr_addr_bram[c]), 32'(t.exp_addr));
        chk("tbl_data", 32'(bus.wr_data_bram[c]), 32'(exp_data[c]));
      end
      chk("tbl_frame_done", 32'(frame_done), 32'(t.exp_fd));
      if (t.exp_fd) chk("tbl_frame_bank", 32'(frame_bank), 32'(t.exp_fb));
      chk("tbl_full", 32'(full), 32'(t.exp_full));
      chk("tbl_err", 32'(err_release), 32'(t.exp_err));
    end

    // ch0 every cycle, ch1/ch2 every other cycle: ch0 must wait, one frame_done.
    do_reset();
    cm = '{0, 0, 0};
    fd_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      v = {(i % 2 == 0), (i % 2 == 0), 1'b1};
      for (int c = 0; c < 3; c++) rdy_m[c] = (cm[c] < 12);
      chk("skew_ready", 32'(bus.in_ready), 32'(rdy_m));
      drive(v, 1'b0);
      tick();
      chk("skew_wr_en", 32'(bus.wr_en_bram), 32'(v & rdy_m));
      for (int c = 0; c < 3; c++) begin
        if (v[c] && rdy_m[c]) begin
          chk("skew_addr", 32'(bus.wr_addr_bram[c]), 32'(cm[c]));
          cm[c]++;
        end
      end
      chk("skew_frame_done", 32'(frame_done), 32'(i == 23));
      if (frame_done) fd_cnt++;
    end
    chk("skew_fd_pulses", 32'(fd_cnt), 32'd1);

    // Release in the commit cycle of frame 2 must not change nfull or stall.
    do_reset();
    run_frame(0, 1'b0);
    chk("c1_full", 32'(full), 32'h0);
    run_frame(1, 1'b1);
    chk("c2_full", 32'(full), 32'h0);
    chk("c2_ready_nostall", 32'(bus.in_ready), 32'h7);
    chk("c2_err", 32'(err_release), 32'h0);
    run_frame(0, 1'b0);
    chk("c3_full", 32'(full), 32'h1);
    chk("c3_ready", 32'(bus.in_ready), 32'h0);
    drive(3'b000, 1'b1);
    tick();
    chk("rel1_full", 32'(full), 32'h0);
    chk("rel1_ready", 32'(bus.in_ready), 32'h7);
    chk("rel1_err", 32'(err_release), 32'h0);
    drive(3'b000, 1'b1);
    tick();
    chk("rel2_err", 32'(err_release), 32'h0);
    drive(3'b000, 1'b1);
    tick();
    chk("rel_empty_err", 32'(err_release), 32'h1);
    drive(3'b000, 1'b0);
    tick();
    chk("err_sticky", 32'(err_release), 32'h1);

    // Reset after five writes in bank 1: everything clears, restart at 0.
    for (int i = 0; i < 5; i++) begin
      drive(3'b111, 1'b0);
      tick();
      chk("pre_rst_addr", 32'(bus.wr_addr_bram[0]), 32'(12 + i));
    end
    #2;
    rst_n = 1'b0;
    bus.in_valid = '0;
    #1;
    chk_cleared();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'h7);
    run_frame(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
